// File: rtl/crossy_pkg.sv
// Shared definitions for the crossing-game obstacle logic.
//   SCREEN_W / SCREEN_H : visible raster size in pixels / rows
//   LFSR_TAPS           : Galois tap mask for x^16+x^14+x^13+x^11
//   lane_t              : per-lane state (position, direction, speed, last row)
//   lfsr_next()         : one Galois step (shift right, xor taps on lsb out)
package crossy_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [9:0] x;        // left edge of the car, 0..639
    logic       dir;      // 1 = moving right
    logic [2:0] speed;    // pixels per move_tick, 1..4
    logic [9:0] prev_ly;  // lane row seen at the previous move_tick
  } lane_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/obstacle_lanes_if.sv
// Signal bundle between the scroll controller / VGA renderer and
// obstacle_lanes.
//   move_tick, scroll_y        : scroll controller outputs
//   video_active, pix_x, pix_y : renderer pixel query
//   player_x, player_y         : player box top-left corner
//   clear_collision            : clears the sticky collision flag
//   obstacle_px, collision     : results from obstacle_lanes
// master drives the query side, slave is the obstacle_lanes block.
// There is no valid/ready pair: every cycle presents a query and the
// result appears exactly one cycle later.
interface obstacle_lanes_if;
  logic       move_tick;
  logic [9:0] scroll_y;
  logic       video_active;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       clear_collision;
  logic       obstacle_px;
  logic       collision;

  modport master (
    output move_tick, scroll_y, video_active, pix_x, pix_y,
           player_x, player_y, clear_collision,
    input  obstacle_px, collision
  );

  modport slave (
    input  move_tick, scroll_y, video_active, pix_x, pix_y,
           player_x, player_y, clear_collision,
    output obstacle_px, collision
  );
endinterface

// File: rtl/obstacle_lanes_lane.sv
// One obstacle lane: holds a single car, moves or reseeds it on
// move_tick, and reports whether the queried pixel lies on the car.
//   clk, reset        : clock, synchronous active-high reset
//   move_tick         : advance the car this cycle
//   scroll_y          : shared vertical scroll offset
//   seed_bits         : low LFSR bits used when the lane wraps to the top
//   pix_x, pix_y      : queried pixel
//   hit               : pixel lies on this lane's car (ungated by video)
module obstacle_lane
  import crossy_pkg::*;
#(
  parameter int LANE_IDX   = 0,
  parameter int LANE_PITCH = 120,
  parameter int CAR_W      = 32,
  parameter int CAR_H      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        move_tick,
  input  logic [9:0]  scroll_y,
  input  logic [12:0] seed_bits,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        hit
);

  localparam logic [10:0] W11  = 11'(SCREEN_W);
  localparam logic [10:0] H11  = 11'(SCREEN_H);
  localparam logic [10:0] BASE = 11'(LANE_IDX * LANE_PITCH);
  localparam lane_t RST = '{
    x:       10'((LANE_IDX * 160) % SCREEN_W),
    dir:     1'((LANE_IDX % 2) == 0),
    speed:   3'((LANE_IDX % 4) + 1),
    prev_ly: 10'((LANE_IDX * LANE_PITCH) % SCREEN_H)
  };

  lane_t              st, st_next;
  logic [10:0]        ly_raw, right_sum, seed_x, ly_end;
  logic [9:0]         ly, dx_mod;
  logic signed [10:0] left_diff, dx;
  logic               row_hit, col_hit;

  // Lane row follows the scroll offset with a single wrap back into range.
  assign ly_raw = BASE + {1'b0, scroll_y};
  assign ly     = (ly_raw >= H11) ? 10'(ly_raw - H11) : ly_raw[9:0];

  assign right_sum = {1'b0, st.x} + {8'd0, st.speed};
  assign left_diff = $signed({1'b0, st.x}) - $signed({8'd0, st.speed});
  assign seed_x    = {1'b0, seed_bits[9:0]};

  always_comb begin
    st_next = st;
    if (move_tick) begin
      // A row that went backwards means the lane scrolled off the bottom
      // and reappeared at the top: give it a fresh car instead of moving.
      if (ly < st.prev_ly) begin
        st_next.x     = (seed_x >= W11) ? 10'(seed_x - W11) : seed_bits[9:0];
        st_next.dir   = seed_bits[10];
        st_next.speed = {1'b0, seed_bits[12:11]} + 3'd1;
      end else if (st.dir) begin
        st_next.x = (right_sum >= W11) ? 10'(right_sum - W11) : right_sum[9:0];
      end else begin
        st_next.x = left_diff[10] ? 10'(left_diff + 11'sd640) : left_diff[9:0];
      end
      st_next.prev_ly = ly;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st <= RST;
    else       st <= st_next;
  end

  // Rows clip at the screen bottom; columns wrap so a car can straddle
  // the left/right edges.
  assign ly_end  = {1'b0, ly} + 11'(CAR_H);
  assign row_hit = (pix_y >= ly) && ({1'b0, pix_y} < ly_end) && ({1'b0, pix_y} < H11);
  assign dx      = $signed({1'b0, pix_x}) - $signed({1'b0, st.x});
  assign dx_mod  = dx[10] ? 10'(dx + 11'sd640) : dx[9:0];
  assign col_hit = ({1'b0, dx_mod} < 11'(CAR_W));
  assign hit     = row_hit && col_hit;

endmodule

// File: rtl/obstacle_lanes.sv
// Obstacle lanes for the crossing game: NUM_LANES cars that ride the
// scroll offset, per-pixel obstacle lookup for the renderer and a sticky
// player/obstacle collision flag.
//   clk, reset : clock, synchronous active-high reset
//   bus        : obstacle_lanes_if.slave (scroll, pixel query, player box,
//                clear_collision in; obstacle_px, collision out)
// obstacle_px is registered (one cycle after the query); collision rises
// on the same edge as the matching obstacle_px.
module obstacle_lanes
  import crossy_pkg::*;
#(
  parameter int          NUM_LANES  = 4,
  parameter int          LANE_PITCH = 120,
  parameter int          CAR_W      = 32,
  parameter int          CAR_H      = 16,
  parameter int          PLAYER_W   = 16,
  parameter int          PLAYER_H   = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic              clk,
  input logic              reset,
  obstacle_lanes_if.slave  bus
);

  logic [15:0]          lfsr;
  logic [NUM_LANES-1:0] lane_hit;
  logic                 pixel_hit, in_box_x, in_box_y, coll_set;
  logic                 px_q, coll_q;

  // Free-running so reseeds depend on how long the game has been idle.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    obstacle_lane #(
      .LANE_IDX  (i),
      .LANE_PITCH(LANE_PITCH),
      .CAR_W     (CAR_W),
      .CAR_H     (CAR_H)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .move_tick(bus.move_tick),
      .scroll_y (bus.scroll_y),
      .seed_bits(lfsr[12:0]),
      .pix_x    (bus.pix_x),
      .pix_y    (bus.pix_y),
      .hit      (lane_hit[i])
    );
  end

  assign pixel_hit = bus.video_active && (|lane_hit);
  assign in_box_x  = (bus.pix_x >= bus.player_x) &&
                     ({1'b0, bus.pix_x} < ({1'b0, bus.player_x} + 11'(PLAYER_W)));
  assign in_box_y  = (bus.pix_y >= bus.player_y) &&
                     ({1'b0, bus.pix_y} < ({1'b0, bus.player_y} + 11'(PLAYER_H)));
  assign coll_set  = pixel_hit && in_box_x && in_box_y;

  // A hit on the player box wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_q   <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      px_q <= pixel_hit;
      if (coll_set)                 coll_q <= 1'b1;
      else if (bus.clear_collision) coll_q <= 1'b0;
    end
  end

  assign bus.obstacle_px = px_q;
  assign bus.collision   = coll_q;

endmodule

// File: doc/obstacle_lanes.md
# obstacle_lanes

Downstream consumer of the vertical scroll controller's outputs. Holds one car per horizontal lane and advances every car on each `move_tick` pulse. Lanes ride the shared scroll offset and are reseeded pseudo-randomly when they wrap back to the top of the screen. Answers per-pixel "is obstacle" queries for the VGA renderer and latches a sticky player/obstacle collision flag.

## Interface
- `NUM_LANES`, 4: lane/car count (1..8).
- `LANE_PITCH`, 120: vertical spacing of lane bases, in rows.
- `CAR_W`, 32: car width in pixels.
- `CAR_H`, 16: car height in pixels.
- `PLAYER_W`, 16: player box width.
- `PLAYER_H`, 16: player box height.
- `LFSR_SEED`, 16'hACE1: LFSR reset value, nonzero.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `move_tick` in 1: one-cycle pulse from scroll controller; `scroll_y` is already updated in this cycle.
- `scroll_y` in 10: vertical scroll offset, 0..479.
- `video_active` in 1: current pixel is visible.
- `pix_x` in 10: current pixel column, 0..639.
- `pix_y` in 10: current pixel row, 0..479.
- `player_x` in 10: player box left column.
- `player_y` in 10: player box top row.
- `clear_collision` in 1: clears the sticky collision flag.
- `obstacle_px` out 1: registered; pixel lies on a car.
- `collision` out 1: sticky; player box overlapped a car.

## Operation
Per-lane state: `x` (10b, 0..639), `dir` (1 = right), `speed` (3b, 1..4), `prev_ly` (10b).
- Reset values:
  - lane i `x = i*160 mod 640`.
  - `dir` = 1 for even i, 0 for odd i.
  - `speed = (i mod 4)+1`.
  - `prev_ly = i*LANE_PITCH mod 480`.
  - LFSR = `LFSR_SEED`.
  - `obstacle_px` = 0, `collision` = 0.
- Lane row: `ly = i*LANE_PITCH + scroll_y`. If the sum is ≥480, subtract 480. Use 11-bit intermediate.
- Car footprint:
  - Rows `[ly, ly+CAR_H)`, clipped at 480, no vertical wrap.
  - Columns: `(pix_x - x) mod 640 < CAR_W`, so cars wrap horizontally.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clock, including when idle.
- On `move_tick`, per lane:
  - Wrap detect: if `ly < prev_ly`, the lane wrapped and is reseeded:
    - `x = L[9:0]`, minus 640 if that value is ≥640.
    - `dir = L[10]`.
    - `speed = L[12:11]+1`.
    - L is the current LFSR value. All lanes reseeding in the same cycle receive the same L.
  - Otherwise the car moves:
    - Right: `x = x+speed`, minus 640 if the result is ≥640.
    - Left: `x = x-speed`, plus 640 on underflow. Use 11-bit signed intermediate.
  - Reseed takes priority over move in the same cycle.
  - `prev_ly` takes the new `ly` on every `move_tick`.
- No state changes when `move_tick` = 0, except the LFSR.
- Pixel hit: the OR across lanes of the footprint test, gated by `video_active`.
- Collision set condition, all in the same cycle:
  - pixel hit, and
  - `pix_x` in `[player_x, player_x+PLAYER_W)`, and
  - `pix_y` in `[player_y, player_y+PLAYER_H)`.
- Collision flag behaviour:
  - Set: `collision` ← 1.
  - Else if `clear_collision`: `collision` ← 0.
  - Set wins over clear.

## Timing
- `obstacle_px`: one-cycle latency from the `pix_*` / `video_active` inputs.
- `collision`: rises in the same cycle as the matching `obstacle_px`; held until cleared.
- Lane state updates on the clock edge that samples `move_tick`=1. Pixel queries from the next cycle use the new positions.
- Consecutive `move_tick` pulses (back-to-back cycles) are each honoured.
- `scroll_y` unchanged across a `move_tick` → no wrap detected, cars move normally.
- Reset mid-operation: all state returns to reset values on the next edge. `obstacle_px` is 0 in the following cycle.

## Structure
- Shared package `crossy_pkg`: `SCREEN_W`=640, `SCREEN_H`=480, LFSR tap mask, lane-state struct (x, dir, speed, prev_ly).
- Sub-module `obstacle_lane`, instanced `NUM_LANES` times. Each instance:
  - Holds lane state.
  - Computes `ly`, move/reseed, and its own hit bit.
  - Takes lane index, `scroll_y`, `move_tick`, LFSR bits, and pixel coordinates.
- Top level holds the LFSR, the hit OR-reduction, the player-box compare, and the output registers.

## Test plan
- Reset:
  - After reset, lane x = 0, 160, 320, 480; `obstacle_px`=0; `collision`=0.
  - 100 idle cycles change nothing.
- Move:
  - `scroll_y`=0, one `move_tick` → lane0 x=1, lane1 x=158, lane2 x=323, lane3 x=476.
- Horizontal wrap:
  - Lane0 x=639 right speed 1 + tick → 0.
  - Lane1 x=1 left speed 2 + tick → 639.
- Pixel query (`scroll_y`=10, lane0 x=0):
  - Pixel (5,12), active → `obstacle_px`=1 one cycle later.
  - (40,12) → 0.
  - (5,30) → 0.
  - Same as the first case with `video_active`=0 → 0.
- Collision:
  - Player (0,10), pixel (3,11) on lane0 → `collision`=1 next cycle; stays 1 after the pixel moves away.
  - `clear_collision` pulse → 0.
  - Clear coincident with a hit → stays 1.
- Vertical reseed:
  - `scroll_y` steps 478→0 with a tick: lane0 reloads from the model LFSR value instead of moving; other lanes move normally.
  - Assert `reset` during this sequence → reset values restored next cycle.
